// File: rtl/oflow_score_board.sv
// Per-frame candidate store: PEs load best/fallback (score, id) pairs, conflict
// resolution reads and re-points them, then each valid entry's resolved id is streamed out.
module oflow_score_board #(
  parameter int NUM_PE    = 8,
  parameter int NUM_ROW   = 4,
  parameter int PE_LEN    = $clog2(NUM_PE),
  parameter int ROW_LEN   = $clog2(NUM_ROW),
  parameter int SCORE_LEN = 11,
  parameter int ID_LEN    = 12
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_load,
  input  logic                 wr_en_pe,
  input  logic [PE_LEN-1:0]    wr_pe,
  input  logic [ROW_LEN-1:0]   wr_row,
  input  logic [SCORE_LEN-1:0] wr_score_best,
  input  logic [SCORE_LEN-1:0] wr_score_fb,
  input  logic [ID_LEN-1:0]    wr_id_best,
  input  logic [ID_LEN-1:0]    wr_id_fb,
  input  logic                 frame_done,
  output logic                 load_ready,
  output logic                 start_cr,
  input  logic                 done_cr,
  input  logic [ROW_LEN-1:0]   row_sel_from_cr,
  input  logic [PE_LEN-1:0]    pe_sel_from_cr,
  output logic [SCORE_LEN-1:0] score_to_cr,
  output logic [ID_LEN-1:0]    id_to_cr,
  input  logic [ROW_LEN-1:0]   row_to_change,
  input  logic [PE_LEN-1:0]    pe_to_change,
  input  logic                 data_to_score_board,
  input  logic                 write_to_pointer,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_LEN-1:0]   out_row,
  output logic [PE_LEN-1:0]    out_pe,
  output logic [ID_LEN-1:0]    out_id,
  output logic                 dump_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CR,
    S_DUMP
  } state_t;

  localparam logic [ROW_LEN-1:0] LAST_ROW = ROW_LEN'(NUM_ROW - 1);
  localparam logic [PE_LEN-1:0]  LAST_PE  = PE_LEN'(NUM_PE - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_start_cr;
  logic   r_dump_done;
  logic   w_start_cr_nxt;
  logic   w_dump_done_nxt;

  logic                 r_valid      [NUM_ROW][NUM_PE];
  logic                 r_ptr        [NUM_ROW][NUM_PE];
  logic [SCORE_LEN-1:0] r_score_best [NUM_ROW][NUM_PE];
  logic [SCORE_LEN-1:0] r_score_fb   [NUM_ROW][NUM_PE];
  logic [ID_LEN-1:0]    r_id_best    [NUM_ROW][NUM_PE];
  logic [ID_LEN-1:0]    r_id_fb      [NUM_ROW][NUM_PE];

  logic [ROW_LEN-1:0] r_scan_row;
  logic [PE_LEN-1:0]  r_scan_pe;

  logic w_any_valid;
  logic w_scan_valid;
  logic w_scan_last;
  logic w_scan_adv;
  logic w_rd_valid;
  logic w_rd_ptr;

  // A write landing in the same cycle as frame_done still counts as valid.
  always_comb begin
    w_any_valid = wr_en_pe;
    for (int r = 0; r < NUM_ROW; r++) begin
      for (int p = 0; p < NUM_PE; p++) begin
        w_any_valid = w_any_valid | r_valid[r][p];
      end
    end
  end

  assign w_scan_valid = r_valid[r_scan_row][r_scan_pe];
  assign w_scan_last  = (r_scan_row == LAST_ROW) && (r_scan_pe == LAST_PE);
  assign w_scan_adv   = (r_state == S_DUMP) && (!w_scan_valid || out_ready);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_start_cr_nxt  = 1'b0;
    w_dump_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_load) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (frame_done) begin
          if (w_any_valid) begin
            w_state_nxt    = S_CR;
            w_start_cr_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_IDLE;
            w_dump_done_nxt = 1'b1;
          end
        end
      end
      S_CR: begin
        if (done_cr) w_state_nxt = S_DUMP;
      end
      S_DUMP: begin
        if (w_scan_adv && w_scan_last) begin
          w_state_nxt     = S_IDLE;
          w_dump_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      r_state     <= S_IDLE;
      r_start_cr  <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_cr  <= w_start_cr_nxt;
      r_dump_done <= w_dump_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      r_scan_row <= '0;
      r_scan_pe  <= '0;
    end else if (w_scan_adv) begin
      if (w_scan_last) begin
        r_scan_row <= '0;
        r_scan_pe  <= '0;
      end else if (r_scan_pe == LAST_PE) begin
        r_scan_pe  <= '0;
        r_scan_row <= r_scan_row + 1'b1;
      end else begin
        r_scan_pe  <= r_scan_pe + 1'b1;
      end
    end
  end

  // Control bits per entry; opening a frame wipes the previous frame's state.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int p = 0; p < NUM_PE; p++) begin
          r_valid[r][p] <= 1'b0;
          r_ptr[r][p]   <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_load) begin
            for (int r = 0; r < NUM_ROW; r++) begin
              for (int p = 0; p < NUM_PE; p++) begin
                r_valid[r][p] <= 1'b0;
                r_ptr[r][p]   <= 1'b0;
              end
            end
          end
        end
        S_LOAD: begin
          if (wr_en_pe) begin
            r_valid[wr_row][wr_pe] <= 1'b1;
            r_ptr[wr_row][wr_pe]   <= 1'b0;
          end
        end
        S_CR: begin
          if (write_to_pointer) r_ptr[row_to_change][pe_to_change] <= data_to_score_board;
        end
        default: ;
      endcase
    end
  end

  // NOTE: candidate payload is not reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && wr_en_pe) begin
      r_score_best[wr_row][wr_pe] <= wr_score_best;
      r_score_fb[wr_row][wr_pe]   <= wr_score_fb;
      r_id_best[wr_row][wr_pe]    <= wr_id_best;
      r_id_fb[wr_row][wr_pe]      <= wr_id_fb;
    end
  end

  assign w_rd_valid = r_valid[row_sel_from_cr][pe_sel_from_cr];
  assign w_rd_ptr   = r_ptr[row_sel_from_cr][pe_sel_from_cr];

  assign score_to_cr = !w_rd_valid ? '1 :
                       w_rd_ptr    ? r_score_fb[row_sel_from_cr][pe_sel_from_cr] :
                                     r_score_best[row_sel_from_cr][pe_sel_from_cr];
  assign id_to_cr    = !w_rd_valid ? '1 :
                       w_rd_ptr    ? r_id_fb[row_sel_from_cr][pe_sel_from_cr] :
                                     r_id_best[row_sel_from_cr][pe_sel_from_cr];

  assign load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign start_cr   = r_start_cr;
  assign dump_done  = r_dump_done;
  assign out_valid  = (r_state == S_DUMP) && w_scan_valid;
  assign out_row    = r_scan_row;
  assign out_pe     = r_scan_pe;
  assign out_id     = !out_valid ? '0 :
                      r_ptr[r_scan_row][r_scan_pe] ? r_id_fb[r_scan_row][r_scan_pe] :
                                                     r_id_best[r_scan_row][r_scan_pe];

endmodule

// File: doc/oflow_score_board.md
# oflow_score_board

Per-frame candidate store between the similarity PEs and the conflict-resolution stage. During load, PEs deposit a best and a fallback (score, id) candidate per (row, PE) entry. The block then starts conflict resolution, serves its random reads, applies its pointer updates, and finally streams the resolved id of every valid entry downstream.

## Interface
Parameters:
- NUM_PE, 8, number of PEs (columns)
- NUM_ROW, 4, rows per PE
- PE_LEN, $clog2(NUM_PE) = 3, PE index width
- ROW_LEN, $clog2(NUM_ROW) = 2, row index width
- SCORE_LEN, 11, score width
- ID_LEN, 12, id width

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_N  in  1  synchronous, active-low reset
- start_load  in  1  pulse; opens a frame (accepted only in IDLE)
- wr_en_pe  in  1  PE candidate write strobe (LOAD only)
- wr_pe  in  PE_LEN  PE index of write
- wr_row  in  ROW_LEN  row index of write
- wr_score_best / wr_score_fb  in  SCORE_LEN  best / fallback score
- wr_id_best / wr_id_fb  in  ID_LEN  best / fallback id
- frame_done  in  1  pulse; last PE write of the frame has been issued
- load_ready  out  1  high in IDLE and LOAD
- start_cr  out  1  one-cycle pulse to conflict resolution
- done_cr  in  1  conflict resolution finished
- row_sel_from_cr  in  ROW_LEN  read row
- pe_sel_from_cr  in  PE_LEN  read PE
- score_to_cr  out  SCORE_LEN  score of the selected entry at its current pointer
- id_to_cr  out  ID_LEN  id of the selected entry at its current pointer
- row_to_change / pe_to_change  in  ROW_LEN / PE_LEN  pointer write address
- data_to_score_board  in  1  new pointer value (0 = best, 1 = fallback)
- write_to_pointer  in  1  pointer write strobe
- out_valid  out  1  resolved-entry output valid
- out_ready  in  1  downstream accepts output
- out_row / out_pe  out  ROW_LEN / PE_LEN  address of output entry
- out_id  out  ID_LEN  resolved id
- dump_done  out  1  one-cycle pulse; frame fully emitted

## Operation
- Storage: NUM_ROW×NUM_PE entries. Each entry holds valid, ptr, best {score,id} and fallback {score,id}.
- FSM states and transitions:
  - IDLE: start_load → LOAD. Valid bits and ptr bits clear in the same cycle.
  - LOAD: a wr_en_pe write sets the entry fields and valid=1, and resets ptr to 0. A repeated write to the same address: last write wins. On frame_done: if any entry is valid → CR; else → IDLE with a dump_done pulse.
  - CR: start_cr is high for the first cycle in CR only. Pointer writes apply while in CR. done_cr → DUMP.
  - DUMP: the scan index walks row-major from (0,0) to (NUM_ROW-1, NUM_PE-1).
    - Valid entry: out_valid=1, and the index advances on out_ready.
    - Invalid entry: skipped in one cycle with out_valid=0.
    - After the last index: dump_done pulse, → IDLE.
- CR read port is combinational from storage.
  - ptr=0 selects the best candidate; ptr=1 selects the fallback.
  - An invalid entry reads score all-ones and id all-ones.
- Ignored inputs:
  - wr_en_pe outside LOAD.
  - write_to_pointer outside CR.
  - start_load outside IDLE.
  - frame_done outside LOAD.
  - done_cr outside CR.
- Pointer write to an invalid entry: ptr updates; read still returns all-ones.
- out_id = ptr ? id_fb : id_best.

## Timing
- Reset (reset_N=0 at an edge):
  - state IDLE; all valid and ptr bits 0; scan index 0.
  - start_cr=0, out_valid=0, dump_done=0; out_row, out_pe, out_id = 0; load_ready=1 from the next cycle.
  - Reset mid-frame aborts the frame; no dump_done is issued.
- start_load at edge N → LOAD from N+1.
- frame_done together with wr_en_pe in the same cycle: the write is stored, and it counts toward the any-valid check.
- frame_done at edge N → start_cr high during cycle N+1 (registered).
- Read latency: zero cycles.
  - A pointer write at edge N is visible to reads from cycle N+1.
  - A read and a write of the same entry in the same cycle return the old pointer's data.
- done_cr at edge N → first DUMP cycle N+1.
- DUMP lasts NUM_ROW×NUM_PE cycles plus stall cycles. Stall cycles are cycles with out_valid=1 and out_ready=0.
- Output hold rule: while out_valid=1 and out_ready=0, out_row, out_pe and out_id hold stable.
- dump_done is high in the cycle after the final index is consumed; the state is IDLE on that same cycle.

## Test plan
- Full frame: load all 32 entries with best id = row*8+pe, fallback id = 100+row*8+pe, no pointer writes, out_ready=1.
  - Expect one start_cr pulse, then 32 outputs in row-major order with ids 0..31.
  - Expect dump_done 32 cycles after DUMP entry.
- Pointer flip: set ptr of (2,5) to 1 in CR.
  - A read of (2,5) in the next cycle returns the fallback score and id 121.
  - The dump emits out_id=121 at (2,5).
- Sparse frame: only (0,0) and (3,7) are written.
  - Reads of (1,1) give score 0x7FF and id 0xFFF.
  - Exactly two out_valid beats; dump_done 32 cycles after DUMP entry.
- Backpressure: out_ready=0 for 5 cycles on the first beat.
  - out_* holds stable throughout; no beat is lost or duplicated; total DUMP = 37 cycles.
- Empty frame: start_load then frame_done with no writes.
  - No start_cr; dump_done the next cycle; back to IDLE.
- Reset mid-CR: reset_N=0 for one cycle.
  - All outputs 0, IDLE state; a following done_cr is ignored; a new frame runs normally.
